// File: rtl/dmem_pkg.sv
// Shared types and constants for the clocked data memory bank.
package dmem_pkg;

    localparam int BYTE_W = 8;
    localparam int WCNT_W = 4;
    localparam int INIT_N = 10;
    localparam int unsigned INIT_WORDS [INIT_N] = '{2, 5, 17, 4, 1, 19, 20, 9, 5, 11};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    function automatic int clog2(input int unsigned v);
        int          r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte-lane writes and a registered read port.
// The read register returns zero whenever no read is issued, so it can drive the response bus directly.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 128,
    parameter int INIT_EN = 1,
    localparam int LANES  = DATA_W / BYTE_W,
    localparam int IDX_W  = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LANES-1:0]  be,
    output logic [DATA_W-1:0] rdata
);

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t preload();
        mem_t img;
        foreach (img[i]) begin
            if (INIT_EN != 0 && i < INIT_N) img[i] = DATA_W'(INIT_WORDS[i]);
            else                            img[i] = 'x;
        end
        return img;
    endfunction

    // Power-up image; reset never touches the contents.
    mem_t mem = preload();

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (be[l]) mem[idx][l*BYTE_W +: BYTE_W] <= wdata[l*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata <= '0;
        else if (rd_en) rdata <= mem[idx];
        else            rdata <= '0;
    end

endmodule

// File: rtl/dmem_sync_bank.sv
// Clocked data memory bank: valid/ready request, programmable wait states, one-cycle response strobe.
// Misaligned or out-of-range accesses are answered with rsp_err and never reach the array.
module dmem_sync_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 128,
    parameter int WAIT_CYC = 1,
    parameter int INIT_EN  = 1,
    localparam int LANES   = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int                OFF_W     = clog2(LANES);
    localparam int                IDX_W     = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LOAD = (WAIT_CYC > 0) ? WCNT_W'(WAIT_CYC - 1) : '0;
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LANES - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic [ADDR_W-1:0] word_idx;
    logic              addr_err;
    logic              accept;
    logic              arr_wr, arr_rd;

    logic              we_p0;
    logic              err_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [LANES-1:0]  be_p0;

    assign accept   = req_valid && req_ready;
    assign word_idx = req_addr >> OFF_W;
    assign addr_err = ((req_addr & OFF_MASK) != '0) || ({1'b0, word_idx} >= DEPTH_L);

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    wcnt_nxt  = WAIT_LOAD;
                    state_nxt = (WAIT_CYC > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (wcnt == '0) state_nxt = ACCESS;
                else            wcnt_nxt  = wcnt - 1'b1;
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and response strobes; ready is registered from the next state so it rises one edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wcnt      <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= (state == ACCESS);
            rsp_err   <= (state == ACCESS) && err_p0;
        end
    end

    // Stage p0: request captured on accept and held until the array operation.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            err_p0   <= addr_err;
            idx_p0   <= word_idx[IDX_W-1:0];
            wdata_p0 <= req_wdata;
            be_p0    <= req_be;
        end
    end

    assign arr_wr = (state == ACCESS) && we_p0 && !err_p0;
    assign arr_rd = (state == ACCESS) && !we_p0 && !err_p0;

    dmem_array #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .INIT_EN (INIT_EN)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (arr_wr),
        .rd_en (arr_rd),
        .idx   (idx_p0),
        .wdata (wdata_p0),
        .be    (be_p0),
        .rdata (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_sync_bank.sv
// Bench for dmem_sync_bank: three instances (WAIT_CYC 1, 0, 3) checked against a byte-level memory model.
module tb_dmem_sync_bank;

    localparam int WC [3] = '{1, 0, 3};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [3];
    logic        req_we    [3];
    logic [9:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    wire         req_ready [3];
    wire         rsp_valid [3];
    wire  [31:0] rsp_rdata [3];
    wire         rsp_err   [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] mdl [3][128];
    logic [3:0]  kn  [3][128];
    int          acc_q [3][$];
    rsp_t        rsp_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_sync_bank #(.WAIT_CYC(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
    dmem_sync_bank #(.WAIT_CYC(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
    dmem_sync_bank #(.WAIT_CYC(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    // Accepts and responses are logged mid-cycle with the current cycle stamp.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (req_valid[d] && req_ready[d]) acc_q[d].push_back(cyc);
            if (rsp_valid[d]) begin
                rsp_t r;
                r.rdata = rsp_rdata[d];
                r.err   = rsp_err[d];
                r.cyc   = cyc;
                rsp_q[d].push_back(r);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s ready%0d", tag, d), 64'(req_ready[d]), 0);
            chk($sformatf("%s valid%0d", tag, d), 64'(rsp_valid[d]), 0);
            chk($sformatf("%s rdata%0d", tag, d), 64'(rsp_rdata[d]), 0);
            chk($sformatf("%s err%0d", tag, d), 64'(rsp_err[d]), 0);
        end
    endtask

    // One complete transaction; expectations come from the model, which is then updated.
    task automatic do_acc(input int d, input logic we, input logic [9:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input string tag,
                          output logic [31:0] rd, output logic er);
        int          k, ac, w;
        logic        exp_err;
        logic [31:0] exp_rd, msk;
        rsp_t        rs;
        rd = '0;
        er = 1'b0;
        req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd; req_be[d] = be;
        req_valid[d] = 1'b1;
        k = 0;
        while (acc_q[d].size() == 0 && k < 50) begin @(posedge clk); k++; end
        if (acc_q[d].size() == 0) begin
            chk({tag, " accept timeout"}, 0, 1);
            #1 req_valid[d] = 1'b0;
            return;
        end
        ac = acc_q[d].pop_front();
        #1 req_valid[d] = 1'b0;
        k = 0;
        while (rsp_q[d].size() == 0 && k < 50) begin @(posedge clk); k++; end
        if (rsp_q[d].size() == 0) begin
            chk({tag, " response timeout"}, 0, 1);
            #1;
            return;
        end
        rs = rsp_q[d].pop_front();
        #1;
        rd = rs.rdata;
        er = rs.err;
        w = int'(addr) / 4;
        exp_err = (addr % 4 != 0) || (w >= 128);
        exp_rd = '0;
        msk = '1;
        if (!we && !exp_err) begin
            exp_rd = mdl[d][w];
            for (int l = 0; l < 4; l++) msk[8*l +: 8] = {8{kn[d][w][l]}};
        end
        chk({tag, " err"}, 64'(rs.err), 64'(exp_err));
        chk({tag, " rdata"}, 64'(rs.rdata & msk), 64'(exp_rd & msk));
        chk({tag, " latency"}, 64'(rs.cyc - ac), 64'(WC[d] + 2));
        if (we && !exp_err) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) begin
                    mdl[d][w][8*l +: 8] = wd[8*l +: 8];
                    kn[d][w][l] = 1'b1;
                end
            end
        end
    endtask

    // Reads words 0..n-1 with req_valid held high the whole time.
    task automatic burst(input int d, input int n);
        int   k, ac, prev;
        rsp_t rs;
        prev = 0;
        req_we[d] = 1'b0; req_be[d] = '0; req_wdata[d] = '0;
        req_valid[d] = 1'b1;
        for (int i = 0; i < n; i++) begin
            req_addr[d] = 10'(i * 4);
            k = 0;
            while (acc_q[d].size() == 0 && k < 50) begin @(posedge clk); k++; end
            if (acc_q[d].size() == 0) begin
                chk($sformatf("burst%0d accept timeout", d), 0, 1);
                break;
            end
            ac = acc_q[d].pop_front();
            if (i > 0) chk($sformatf("burst%0d spacing %0d", d, i), 64'(ac - prev), 64'(WC[d] + 3));
            prev = ac;
            #1;
        end
        req_valid[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            k = 0;
            while (rsp_q[d].size() == 0 && k < 50) begin @(posedge clk); k++; end
            if (rsp_q[d].size() == 0) begin
                chk($sformatf("burst%0d response timeout", d), 0, 1);
                break;
            end
            rs = rsp_q[d].pop_front();
            chk($sformatf("burst%0d word%0d rdata", d, i), 64'(rs.rdata), 64'(mdl[d][i]));
            chk($sformatf("burst%0d word%0d err", d, i), 64'(rs.err), 0);
        end
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          k;
        int unsigned init_vals [10] = '{2, 5, 17, 4, 1, 19, 20, 9, 5, 11};

        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0;   req_be[d] = '0;
            for (int w = 0; w < 128; w++) begin
                mdl[d][w] = (w < 10) ? init_vals[w] : 32'h0;
                kn[d][w]  = (w < 10) ? 4'hF : 4'h0;
            end
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("ready before edge %0d", d), 64'(req_ready[d]), 0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("ready after edge %0d", d), 64'(req_ready[d]), 1);

        do_acc(0, 1'b0, 10'h008, 32'h0, 4'h0, "rd w2", rd, er);
        chk("rd w2 value", 64'(rd), 17);

        do_acc(0, 1'b1, 10'h000, 32'hDEADBEEF, 4'b0101, "wr w0", rd, er);
        chk("wr w0 rdata zero", 64'(rd), 0);
        do_acc(0, 1'b0, 10'h000, 32'h0, 4'h0, "rd w0", rd, er);
        chk("rd w0 merged", 64'(rd), 64'h00AD00EF);

        do_acc(0, 1'b0, 10'h006, 32'h0, 4'h0, "misaligned", rd, er);
        chk("misaligned err", 64'(er), 1);
        chk("misaligned rdata", 64'(rd), 0);
        do_acc(0, 1'b0, 10'h200, 32'h0, 4'h0, "out of range", rd, er);
        chk("out of range err", 64'(er), 1);
        do_acc(0, 1'b1, 10'h006, 32'hFFFFFFFF, 4'hF, "misaligned wr", rd, er);
        chk("misaligned wr err", 64'(er), 1);
        do_acc(0, 1'b0, 10'h004, 32'h0, 4'h0, "rd w1 intact", rd, er);
        chk("rd w1 intact value", 64'(rd), 5);

        do_acc(0, 1'b1, 10'h00C, 32'h12345678, 4'h0, "be0 wr", rd, er);
        chk("be0 wr err", 64'(er), 0);
        do_acc(0, 1'b0, 10'h00C, 32'h0, 4'h0, "rd w3", rd, er);
        chk("rd w3 value", 64'(rd), 4);

        burst(1, 10);
        burst(2, 10);

        // Write to word 5 aborted by reset while waiting.
        req_we[0] = 1'b1; req_addr[0] = 10'h014; req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF;
        req_valid[0] = 1'b1;
        k = 0;
        while (acc_q[0].size() == 0 && k < 50) begin @(posedge clk); k++; end
        if (acc_q[0].size() == 0) chk("abort accept timeout", 0, 1);
        else void'(acc_q[0].pop_front());
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort no response", 64'(rsp_q[0].size()), 0);
        do_acc(0, 1'b0, 10'h014, 32'h0, 4'h0, "rd w5 after abort", rd, er);
        chk("rd w5 after abort value", 64'(rd), 19);

        for (int i = 0; i < 60; i++) begin
            int          d, sel;
            logic [9:0]  a;
            logic        we;
            d   = i % 3;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = 10'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (sel == 1) a = 10'($urandom_range(128, 255) * 4);
            else               a = 10'($urandom_range(0, 15) * 4);
            we = 1'($urandom_range(0, 1));
            do_acc(d, we, a, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i), rd, er);
        end

        repeat (20) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("stray accepts %0d", d), 64'(acc_q[d].size()), 0);
            chk($sformatf("stray responses %0d", d), 64'(rsp_q[d].size()), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
